// File: rtl/uninasoc_irq_ctrl.sv
// uninasoc_irq_ctrl
// Platform interrupt controller: synchronises NUM_IRQ asynchronous sources,
// qualifies each as edge or level, masks them, and presents the lowest-index
// pending+enabled line to the core. Software services interrupts through a
// single-outstanding claim/complete handshake on a simple register port.
//
// Register map (byte address, word aligned):
//   0x0 ENABLE   per-line enable mask
//   0x4 MODE     1 = edge (sticky), 0 = level (follows synced input)
//   0x8 PENDING  live pending bits; write 1 clears edge-mode bits
//   0xC CLAIM    read claims the winner (returns id, 0 = none);
//                write the in-service id to complete

module uninasoc_irq_ctrl #(
    parameter int NUM_IRQ     = 3,
    parameter int SYNC_STAGES = 2,
    localparam int ID_WIDTH   = $clog2(NUM_IRQ + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NUM_IRQ-1:0]  irq_src_i,
    input  logic                reg_req_i,
    input  logic                reg_we_i,
    input  logic [3:0]          reg_addr_i,
    input  logic [31:0]         reg_wdata_i,
    output logic [31:0]         reg_rdata_o,
    output logic                reg_ack_o,
    output logic                irq_o,
    output logic [ID_WIDTH-1:0] irq_id_o
);

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_CLAIMED = 1'b1;

    localparam logic [1:0] SEL_ENABLE  = 2'd0;
    localparam logic [1:0] SEL_MODE    = 2'd1;
    localparam logic [1:0] SEL_PENDING = 2'd2;
    localparam logic [1:0] SEL_CLAIM   = 2'd3;

    // Input path
    logic [NUM_IRQ-1:0] r_sync [SYNC_STAGES];
    logic [NUM_IRQ-1:0] r_s_q;
    logic [NUM_IRQ-1:0] r_rise;
    logic [NUM_IRQ-1:0] w_s;

    // Software-visible state
    logic [NUM_IRQ-1:0]  r_enable;
    logic [NUM_IRQ-1:0]  r_mode;
    logic [NUM_IRQ-1:0]  r_pending;
    logic [0:0]          r_state;
    logic [ID_WIDTH-1:0] r_svc_id;

    // Registered outputs
    logic                r_ack;
    logic [31:0]         r_rdata;
    logic                r_irq;
    logic [ID_WIDTH-1:0] r_irq_id;

    // Decode, arbitration and next-state
    logic                w_aligned;
    logic                w_rd;
    logic                w_wr;
    logic [1:0]          w_sel;
    logic                w_wr_enable;
    logic                w_wr_mode;
    logic                w_wr_pend;
    logic                w_wr_claim;
    logic                w_rd_claim;
    logic [NUM_IRQ-1:0]  w_wdata_bits;
    logic [NUM_IRQ-1:0]  w_cand;
    logic                w_any;
    logic [ID_WIDTH-1:0] w_win_id;
    logic [NUM_IRQ-1:0]  w_win_oh;
    logic [0:0]          w_state_next;
    logic [ID_WIDTH-1:0] w_svc_id_next;
    logic                w_claim_take;
    logic [NUM_IRQ-1:0]  w_mode_chg;
    logic [NUM_IRQ-1:0]  w_clr;
    logic [NUM_IRQ-1:0]  w_pending_next;
    logic [31:0]         w_rdata_next;
    logic                w_unused;

    assign w_s          = r_sync[SYNC_STAGES-1];
    assign w_aligned    = (reg_addr_i[1:0] == 2'b00);
    assign w_rd         = reg_req_i & ~reg_we_i & w_aligned;
    assign w_wr         = reg_req_i &  reg_we_i & w_aligned;
    assign w_sel        = reg_addr_i[3:2];
    assign w_wr_enable  = w_wr && (w_sel == SEL_ENABLE);
    assign w_wr_mode    = w_wr && (w_sel == SEL_MODE);
    assign w_wr_pend    = w_wr && (w_sel == SEL_PENDING);
    assign w_wr_claim   = w_wr && (w_sel == SEL_CLAIM);
    assign w_rd_claim   = w_rd && (w_sel == SEL_CLAIM);
    assign w_wdata_bits = reg_wdata_i[NUM_IRQ-1:0];
    assign w_cand       = r_pending & r_enable;
    assign w_any        = |w_cand;

    // Write-data bits above the implemented lines are intentionally dropped.
    assign w_unused = &{1'b0, reg_wdata_i};

    // Synchroniser chain plus one extra flop and a registered rise pulse.
    // NOTE: synchroniser flops are reset so a reset release never presents stale levels as new edges.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int j = 0; j < SYNC_STAGES; j++) r_sync[j] <= '0;
            r_s_q  <= '0;
            r_rise <= '0;
        end else begin
            // NOTE: non-blocking assignments make every stage shift by exactly one cycle, independent of statement order.
            r_sync[0] <= irq_src_i;
            for (int j = 1; j < SYNC_STAGES; j++) r_sync[j] <= r_sync[j-1];
            r_s_q  <= w_s;
            r_rise <= w_s & ~r_s_q;
        end
    end

    // Lowest set index of the candidate vector wins.
    always_comb begin
        // NOTE: defaults first so no path through this block leaves a value held (no latch).
        w_win_id = '0;
        w_win_oh = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_cand[i]) begin
                w_win_id = ID_WIDTH'(i + 1);
                w_win_oh = NUM_IRQ'(1) << i;
            end
        end
    end

    // Claim/complete state machine.
    always_comb begin
        w_state_next  = r_state;
        w_svc_id_next = r_svc_id;
        w_claim_take  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_rd_claim && w_any) begin
                    w_state_next  = ST_CLAIMED;
                    w_svc_id_next = w_win_id;
                    w_claim_take  = 1'b1;
                end
            end
            ST_CLAIMED: begin
                if (w_wr_claim && (reg_wdata_i[ID_WIDTH-1:0] == r_svc_id)) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Pending update: mode change clears, edge bits are sticky with set winning, level bits follow the input.
    always_comb begin
        w_mode_chg = w_wr_mode ? (w_wdata_bits ^ r_mode) : '0;
        w_clr      = (w_wr_pend ? w_wdata_bits : '0) | (w_claim_take ? w_win_oh : '0);
        w_pending_next = ~w_mode_chg
                       & ((r_mode & ((r_pending & ~w_clr) | r_rise)) | (~r_mode & w_s));
    end

    // Read data selection; only aligned reads return data.
    always_comb begin
        w_rdata_next = '0;
        if (w_rd) begin
            case (w_sel)
                SEL_ENABLE:  w_rdata_next = 32'(r_enable);
                SEL_MODE:    w_rdata_next = 32'(r_mode);
                SEL_PENDING: w_rdata_next = 32'(r_pending);
                SEL_CLAIM:   w_rdata_next = w_claim_take ? 32'(w_win_id) : '0;
                default:     w_rdata_next = '0;
            endcase
        end
    end

    // Control/status registers and claim state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_enable  <= '0;
            r_mode    <= '0;
            r_pending <= '0;
            r_state   <= ST_IDLE;
            r_svc_id  <= '0;
        end else begin
            if (w_wr_enable) r_enable <= w_wdata_bits;
            if (w_wr_mode)   r_mode   <= w_wdata_bits;
            r_pending <= w_pending_next;
            r_state   <= w_state_next;
            r_svc_id  <= w_svc_id_next;
        end
    end

    // Registered register-port response and interrupt outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ack    <= 1'b0;
            r_rdata  <= '0;
            r_irq    <= 1'b0;
            r_irq_id <= '0;
        end else begin
            r_ack    <= reg_req_i;
            r_rdata  <= w_rdata_next;
            r_irq    <= w_any && (w_state_next == ST_IDLE);
            r_irq_id <= (w_state_next == ST_CLAIMED) ? w_svc_id_next
                                                     : (w_any ? w_win_id : '0);
        end
    end

    assign reg_ack_o   = r_ack;
    assign reg_rdata_o = r_rdata;
    assign irq_o       = r_irq;
    assign irq_id_o    = r_irq_id;

endmodule

// File: tb/tb_uninasoc_irq_ctrl.sv
// tb_uninasoc_irq_ctrl
// Directed bench for the interrupt controller (NUM_IRQ=3, SYNC_STAGES=2).
// Inputs change on the falling edge; outputs are sampled on the falling edge.

module tb_uninasoc_irq_ctrl;

    localparam int NUM_IRQ = 3;
    localparam int ID_W    = 2;

    localparam logic [3:0] A_ENABLE  = 4'h0;
    localparam logic [3:0] A_MODE    = 4'h4;
    localparam logic [3:0] A_PENDING = 4'h8;
    localparam logic [3:0] A_CLAIM   = 4'hC;

    logic               clk_i = 1'b0;
    logic               rst_ni = 1'b0;
    logic [NUM_IRQ-1:0] irq_src_i = '0;
    logic               reg_req_i = 1'b0;
    logic               reg_we_i = 1'b0;
    logic [3:0]         reg_addr_i = '0;
    logic [31:0]        reg_wdata_i = '0;
    logic [31:0]        reg_rdata_o;
    logic               reg_ack_o;
    logic               irq_o;
    logic [ID_W-1:0]    irq_id_o;

    int checks = 0;
    int errors = 0;

    logic [31:0] rd;
    logic        ack;

    uninasoc_irq_ctrl #(.NUM_IRQ(NUM_IRQ), .SYNC_STAGES(2)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .irq_src_i   (irq_src_i),
        .reg_req_i   (reg_req_i),
        .reg_we_i    (reg_we_i),
        .reg_addr_i  (reg_addr_i),
        .reg_wdata_i (reg_wdata_i),
        .reg_rdata_o (reg_rdata_o),
        .reg_ack_o   (reg_ack_o),
        .irq_o       (irq_o),
        .irq_id_o    (irq_id_o)
    );

    always #5 clk_i = ~clk_i;

    // One register access, started on a falling edge; returns the response
    // sampled on the following falling edge.
    task automatic reg_rw(input logic we, input logic [3:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic ack_s);
        reg_req_i   = 1'b1;
        reg_we_i    = we;
        reg_addr_i  = addr;
        reg_wdata_i = wdata;
        @(negedge clk_i);
        reg_req_i   = 1'b0;
        reg_we_i    = 1'b0;
        reg_wdata_i = '0;
        rdata       = reg_rdata_o;
        ack_s       = reg_ack_o;
    endtask

    task automatic reg_wr(input logic [3:0] addr, input logic [31:0] wdata);
        logic [31:0] d;
        logic        a;
        reg_rw(1'b1, addr, wdata, d, a);
    endtask

    task automatic reg_rd(input logic [3:0] addr, output logic [31:0] rdata);
        logic a;
        reg_rw(1'b0, addr, 32'd0, rdata, a);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk_i);
    endtask

    task automatic test_reset;
        rst_ni = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            irq_src_i = NUM_IRQ'($urandom);
        end
        checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", irq_o); end
        checks++; if (irq_id_o !== 2'd0) begin errors++; $display("FAIL reset_id got %0d want 0", irq_id_o); end
        checks++; if (reg_ack_o !== 1'b0 || reg_rdata_o !== 32'd0) begin
            errors++; $display("FAIL reset_port got ack=%b rdata=%h want 0/0", reg_ack_o, reg_rdata_o); end
        irq_src_i = '0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        reg_rd(A_ENABLE, rd);
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL reset_enable got %h want 0", rd); end
        reg_rd(A_MODE, rd);
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL reset_mode got %h want 0", rd); end
        reg_rd(A_PENDING, rd);
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL reset_pending got %h want 0", rd); end
    endtask

    task automatic test_edge;
        reg_wr(A_ENABLE, 32'h7);
        reg_wr(A_MODE, 32'h7);
        idle(2);
        irq_src_i = 3'b010;            // sampled at the next rising edge (k)
        @(negedge clk_i);              // after k
        irq_src_i = 3'b000;
        idle(2);                       // after k+2
        @(negedge clk_i);              // after k+3
        checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL edge_early_irq got %b want 0", irq_o); end
        @(negedge clk_i);              // after k+4
        checks++; if (irq_o !== 1'b1 || irq_id_o !== 2'd2) begin
            errors++; $display("FAIL edge_irq got irq=%b id=%0d want 1/2", irq_o, irq_id_o); end
        reg_rw(1'b0, A_CLAIM, 32'd0, rd, ack);
        checks++; if (rd !== 32'd2 || ack !== 1'b1) begin
            errors++; $display("FAIL edge_claim got rd=%0d ack=%b want 2/1", rd, ack); end
        checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL edge_claim_irq got %b want 0", irq_o); end
        reg_rd(A_PENDING, rd);
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL edge_pending got %h want 0", rd); end
        reg_wr(A_CLAIM, 32'd2);
        reg_rd(A_CLAIM, rd);
        checks++; if (rd !== 32'd0 || irq_o !== 1'b0) begin
            errors++; $display("FAIL edge_complete got rd=%0d irq=%b want 0/0", rd, irq_o); end
    endtask

    task automatic test_regmap;
        reg_wr(A_ENABLE, 32'hFFFF_FFFF);
        reg_rd(A_ENABLE, rd);
        checks++; if (rd !== 32'h7) begin errors++; $display("FAIL ro_bits got %h want 7", rd); end
        reg_rw(1'b0, 4'h5, 32'd0, rd, ack);
        checks++; if (rd !== 32'd0 || ack !== 1'b1) begin
            errors++; $display("FAIL misaligned_rd got rd=%h ack=%b want 0/1", rd, ack); end
        @(negedge clk_i);
        checks++; if (reg_ack_o !== 1'b0) begin errors++; $display("FAIL ack_pulse got %b want 0", reg_ack_o); end
        reg_wr(4'h1, 32'd0);           // misaligned ENABLE write is dropped
        reg_rd(A_ENABLE, rd);
        checks++; if (rd !== 32'h7) begin errors++; $display("FAIL misaligned_wr got %h want 7", rd); end
        irq_src_i = 3'b010;
        @(negedge clk_i);
        irq_src_i = 3'b000;
        idle(6);
        reg_rd(A_PENDING, rd);
        checks++; if (rd !== 32'h2) begin errors++; $display("FAIL w1c_before got %h want 2", rd); end
        reg_wr(A_PENDING, 32'h2);
        reg_rd(A_PENDING, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL w1c_after got %h want 0", rd); end
        idle(2);
    endtask

    task automatic test_priority;
        irq_src_i = 3'b101;
        idle(2);
        irq_src_i = 3'b000;
        idle(4);
        reg_rd(A_CLAIM, rd);
        checks++; if (rd !== 32'd1) begin errors++; $display("FAIL prio_first got %0d want 1", rd); end
        reg_wr(A_CLAIM, 32'd1);
        checks++; if (irq_o !== 1'b1 || irq_id_o !== 2'd3) begin
            errors++; $display("FAIL prio_next_irq got irq=%b id=%0d want 1/3", irq_o, irq_id_o); end
        reg_rd(A_CLAIM, rd);
        checks++; if (rd !== 32'd3) begin errors++; $display("FAIL prio_second got %0d want 3", rd); end
        reg_wr(A_CLAIM, 32'd3);
        checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL prio_done got %b want 0", irq_o); end
    endtask

    task automatic test_wrong_id;
        irq_src_i = 3'b001;
        @(negedge clk_i);
        irq_src_i = 3'b000;
        idle(5);
        reg_rd(A_CLAIM, rd);
        checks++; if (rd !== 32'd1) begin errors++; $display("FAIL wid_claim got %0d want 1", rd); end
        reg_wr(A_CLAIM, 32'd3);
        reg_rd(A_CLAIM, rd);
        checks++; if (rd !== 32'd0 || irq_o !== 1'b0 || irq_id_o !== 2'd1) begin
            errors++; $display("FAIL wid_held got rd=%0d irq=%b id=%0d want 0/0/1", rd, irq_o, irq_id_o); end
        reg_wr(A_CLAIM, 32'd1);
        checks++; if (irq_id_o !== 2'd0 || irq_o !== 1'b0) begin
            errors++; $display("FAIL wid_complete got irq=%b id=%0d want 0/0", irq_o, irq_id_o); end
        // A second pulse must be claimable, proving the FSM is back in IDLE.
        irq_src_i = 3'b001;
        @(negedge clk_i);
        irq_src_i = 3'b000;
        idle(5);
        reg_rd(A_CLAIM, rd);
        checks++; if (rd !== 32'd1) begin errors++; $display("FAIL wid_reclaim got %0d want 1", rd); end
        reg_wr(A_CLAIM, 32'd1);
    endtask

    task automatic test_level;
        reg_wr(A_MODE, 32'h0);
        irq_src_i = 3'b100;
        idle(5);
        reg_rd(A_PENDING, rd);
        checks++; if (rd !== 32'h4) begin errors++; $display("FAIL lvl_pending got %h want 4", rd); end
        reg_rd(A_CLAIM, rd);
        checks++; if (rd !== 32'd3) begin errors++; $display("FAIL lvl_claim got %0d want 3", rd); end
        reg_wr(A_CLAIM, 32'd3);
        checks++; if (irq_o !== 1'b1 || irq_id_o !== 2'd3) begin
            errors++; $display("FAIL lvl_reassert got irq=%b id=%0d want 1/3", irq_o, irq_id_o); end
        reg_wr(A_PENDING, 32'h4);      // W1C has no effect on level bits
        reg_rd(A_PENDING, rd);
        checks++; if (rd !== 32'h4) begin errors++; $display("FAIL lvl_w1c got %h want 4", rd); end
        irq_src_i = 3'b000;
        idle(3);
        reg_rd(A_PENDING, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL lvl_drop got %h want 0", rd); end
        // Switching a high level line to edge mode clears it; no new rise follows.
        irq_src_i = 3'b100;
        idle(5);
        reg_wr(A_MODE, 32'h4);
        idle(2);
        reg_rd(A_PENDING, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL mode_chg_clr got %h want 0", rd); end
        irq_src_i = 3'b000;
        idle(4);
    endtask

    task automatic test_race_and_reset;
        reg_wr(A_MODE, 32'h7);
        irq_src_i = 3'b001;            // sampled at edge k; PENDING sets at k+3
        idle(3);                       // after k+2
        reg_wr(A_PENDING, 32'h1);      // W1C lands on edge k+3
        reg_rd(A_PENDING, rd);
        checks++; if (rd !== 32'h1) begin errors++; $display("FAIL race_set_wins got %h want 1", rd); end
        reg_rd(A_CLAIM, rd);
        checks++; if (rd !== 32'd1 || irq_id_o !== 2'd1) begin
            errors++; $display("FAIL race_claim got rd=%0d id=%0d want 1/1", rd, irq_id_o); end
        irq_src_i = 3'b000;
        #2 rst_ni = 1'b0;
        #1;
        checks++; if (irq_o !== 1'b0 || irq_id_o !== 2'd0) begin
            errors++; $display("FAIL async_reset got irq=%b id=%0d want 0/0", irq_o, irq_id_o); end
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        reg_rd(A_PENDING, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL post_reset_pending got %h want 0", rd); end
        reg_rd(A_ENABLE, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL post_reset_enable got %h want 0", rd); end
    endtask

    initial begin
        test_reset();
        test_edge();
        test_regmap();
        test_priority();
        test_wrong_id();
        test_level();
        test_race_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
